// File: rtl/pes_bcd_dntmr_if.sv
// Bus bundle for the two-digit BCD down-counting timer: control/load inputs
// and the registered count/status outputs.
interface pes_bcd_dntmr_if;
   logic       EN;
   logic       LD;
   logic [3:0] DZ;
   logic [3:0] DU;
   logic       GO;
   logic       HLT;
   logic [3:0] Qz;
   logic [3:0] Qu;
   logic [7:0] Q;
   logic       BSY;
   logic       TC;
   logic       ERR;

   modport master (
      output EN, LD, DZ, DU, GO, HLT,
      input  Qz, Qu, Q, BSY, TC, ERR
   );

   modport slave (
      input  EN, LD, DZ, DU, GO, HLT,
      output Qz, Qu, Q, BSY, TC, ERR
   );
endinterface

// File: rtl/pes_bcd_dntmr.sv
// Two-digit BCD down-counting timer (99..00) with parallel load, pause/resume,
// one-cycle terminal-count pulse, optional auto-reload and sticky invalid-load flag.
module pes_bcd_dntmr #(
   parameter bit         AUTO_RLD = 1'b0,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic             CK,
   input  logic             RST,
   pes_bcd_dntmr_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Borrow from the tens digit when the units digit is already zero.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] != 4'd0) begin
         r = {v[7:4], v[3:0] - 4'd1};
      end else begin
         r = {v[7:4] - 4'd1, 4'd9};
      end
      return r;
   endfunction

   // A non-BCD reset value would put illegal digits on the display path.
   localparam logic [7:0] RST_SAFE = bcd_ok(RST_VAL) ? RST_VAL : 8'h00;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] rld_q, rld_d;
   logic       tc_q, tc_d;
   logic       bsy_q, bsy_d;
   logic       err_q, err_d;
   logic [7:0] ld_val_s;

   assign ld_val_s = {bus.DZ, bus.DU};

   // Next-state logic; priority LD > HLT > GO > EN tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rld_d   = rld_q;
      err_d   = err_q;
      tc_d    = 1'b0;
      if (bus.LD) begin
         if (bcd_ok(ld_val_s)) begin
            cnt_d   = ld_val_s;
            rld_d   = ld_val_s;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end else begin
            err_d   = 1'b1;
         end
      end else if (bus.HLT) begin
         if (state_q == S_RUN) begin
            state_d = S_PAUSE;
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            S_IDLE, S_PAUSE: begin
               if (bus.GO && (cnt_q != 8'h00)) begin
                  state_d = S_RUN;
               end else begin
                  state_d = state_q;
               end
            end
            S_DONE: begin
               if (bus.GO) begin
                  cnt_d = rld_q;
                  if (rld_q != 8'h00) begin
                     state_d = S_RUN;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d = 8'h00;
               end
            end
            S_RUN: begin
               if (!bus.EN) begin
                  cnt_d = cnt_q;
               end else if (cnt_q == 8'h00) begin
                  // Only reachable with auto-reload: the tick after 00 restarts the period.
                  if (AUTO_RLD && (rld_q != 8'h00)) begin
                     cnt_d = rld_q;
                  end else begin
                     cnt_d   = 8'h00;
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d = bcd_dec(cnt_q);
                  if (cnt_q == 8'h01) begin
                     tc_d = 1'b1;
                     if (!AUTO_RLD) begin
                        state_d = S_DONE;
                     end else begin
                        state_d = S_RUN;
                     end
                  end else begin
                     tc_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = RST_SAFE;
            end
         endcase
      end
      bsy_d = (state_d == S_RUN);
   end

   // State and registered outputs; synchronous reset overrides everything.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= RST_SAFE;
         rld_q   <= RST_SAFE;
         tc_q    <= 1'b0;
         bsy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
         bsy_q   <= bsy_d;
         err_q   <= err_d;
      end
   end

   assign bus.Q   = cnt_q;
   assign bus.Qz  = cnt_q[7:4];
   assign bus.Qu  = cnt_q[3:0];
   assign bus.BSY = bsy_q;
   assign bus.TC  = tc_q;
   assign bus.ERR = err_q;

endmodule

// File: tb/tb_pes_bcd_dntmr.sv
// Bench for pes_bcd_dntmr: one stop-at-00 and one auto-reload instance share
// the same stimulus and are compared every cycle against an integer-valued model.
module tb_pes_bcd_dntmr;

   logic       CK = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, ld = 1'b0, go = 1'b0, hlt = 1'b0;
   logic [3:0] dz = 4'd0, du = 4'd0;
   int         total = 0;
   int         bad = 0;

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
   int      m_val [2];
   int      m_rld [2];
   mstate_t m_st  [2];
   bit      m_err [2];
   bit      m_tc  [2];

   pes_bcd_dntmr_if if0 ();
   pes_bcd_dntmr_if if1 ();

   assign if0.EN = en;  assign if1.EN = en;
   assign if0.LD = ld;  assign if1.LD = ld;
   assign if0.DZ = dz;  assign if1.DZ = dz;
   assign if0.DU = du;  assign if1.DU = du;
   assign if0.GO = go;  assign if1.GO = go;
   assign if0.HLT = hlt; assign if1.HLT = hlt;

   pes_bcd_dntmr #(.AUTO_RLD(1'b0), .RST_VAL(8'h00)) u0 (.CK(CK), .RST(rst), .bus(if0));
   pes_bcd_dntmr #(.AUTO_RLD(1'b1), .RST_VAL(8'h00)) u1 (.CK(CK), .RST(rst), .bus(if1));

   always #5 CK = ~CK;

   // Model: count held as a plain integer 0..99, digits derived by division.
   task automatic mstep(int k);
      bit auto_r = (k == 1);
      m_tc[k] = 1'b0;
      if (rst) begin
         m_val[k] = 0; m_rld[k] = 0; m_st[k] = M_IDLE; m_err[k] = 1'b0;
      end else if (ld) begin
         if (dz <= 4'd9 && du <= 4'd9) begin
            m_val[k] = int'(dz) * 10 + int'(du);
            m_rld[k] = m_val[k];
            m_err[k] = 1'b0;
            m_st[k]  = M_IDLE;
         end else begin
            m_err[k] = 1'b1;
         end
      end else if (hlt) begin
         if (m_st[k] == M_RUN) m_st[k] = M_PAUSE;
      end else if (m_st[k] == M_RUN) begin
         if (en) begin
            if (m_val[k] == 0) begin
               if (auto_r && m_rld[k] != 0) m_val[k] = m_rld[k];
               else m_st[k] = M_DONE;
            end else begin
               m_val[k] = m_val[k] - 1;
               if (m_val[k] == 0) begin
                  m_tc[k] = 1'b1;
                  if (!auto_r) m_st[k] = M_DONE;
               end
            end
         end
      end else if (go) begin
         if (m_st[k] == M_DONE) begin
            m_val[k] = m_rld[k];
            if (m_rld[k] != 0) m_st[k] = M_RUN;
         end else if (m_val[k] != 0) begin
            m_st[k] = M_RUN;
         end
      end
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic chk_all();
      logic [7:0] e;
      e = to_bcd(m_val[0]);
      chk("u0.Q", if0.Q, e);
      chk("u0.Qz", {4'd0, if0.Qz}, {4'd0, e[7:4]});
      chk("u0.Qu", {4'd0, if0.Qu}, {4'd0, e[3:0]});
      chk("u0.BSY", {7'd0, if0.BSY}, {7'd0, m_st[0] == M_RUN});
      chk("u0.TC", {7'd0, if0.TC}, {7'd0, m_tc[0]});
      chk("u0.ERR", {7'd0, if0.ERR}, {7'd0, m_err[0]});
      e = to_bcd(m_val[1]);
      chk("u1.Q", if1.Q, e);
      chk("u1.Qz", {4'd0, if1.Qz}, {4'd0, e[7:4]});
      chk("u1.Qu", {4'd0, if1.Qu}, {4'd0, e[3:0]});
      chk("u1.BSY", {7'd0, if1.BSY}, {7'd0, m_st[1] == M_RUN});
      chk("u1.TC", {7'd0, if1.TC}, {7'd0, m_tc[1]});
      chk("u1.ERR", {7'd0, if1.ERR}, {7'd0, m_err[1]});
   endtask

   task automatic step(bit e, bit l, logic [3:0] z, logic [3:0] u, bit g, bit h, bit r);
      en = e; ld = l; dz = z; du = u; go = g; hlt = h; rst = r;
      @(posedge CK);
      mstep(0);
      mstep(1);
      #1;
      chk_all();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_val[k] = 0; m_rld[k] = 0; m_st[k] = M_IDLE; m_err[k] = 1'b0; m_tc[k] = 1'b0;
      end
      #2;
      // Reset state
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("rst.Q", if0.Q, 8'h00);
      chk("rst.BSY", {7'd0, if0.BSY}, 8'h00);

      // Load 20, run down to 00
      step(1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("ld20.Q", if0.Q, 8'h20);
      chk("ld20.BSY", {7'd0, if0.BSY}, 8'h00);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("go.BSY", {7'd0, if0.BSY}, 8'h01);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t1.Q00", if0.Q, 8'h00);
      chk("t1.TC", {7'd0, if0.TC}, 8'h01);
      chk("t1.BSY", {7'd0, if0.BSY}, 8'h00);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t1.TCone", {7'd0, if0.TC}, 8'h00);
      chk("t1.hold", if0.Q, 8'h00);

      // Borrow from the tens digit
      step(1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t2.09", if0.Q, 8'h09);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t2.08", if0.Q, 8'h08);

      // Invalid load sets ERR and leaves Q
      step(1'b0, 1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'hA, 4'd3, 1'b0, 1'b0, 1'b0);
      chk("t3.ERR1", {7'd0, if0.ERR}, 8'h01);
      chk("t3.Q45", if0.Q, 8'h45);
      step(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      chk("t3.ERR0", {7'd0, if0.ERR}, 8'h00);
      chk("t3.Q12", if0.Q, 8'h12);

      // Pause and resume
      step(1'b0, 1'b1, 4'd3, 4'd8, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t4.Q37", if0.Q, 8'h37);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
      chk("t4.hold", if0.Q, 8'h37);
      chk("t4.BSY0", {7'd0, if0.BSY}, 8'h00);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("t4.BSY1", {7'd0, if0.BSY}, 8'h01);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t4.Q36", if0.Q, 8'h36);

      // Auto-reload period of four ticks
      step(1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t5.Q00", if1.Q, 8'h00);
      chk("t5.TC", {7'd0, if1.TC}, 8'h01);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t5.Q03", if1.Q, 8'h03);
      chk("t5.TC0", {7'd0, if1.TC}, 8'h00);
      chk("t5.BSY", {7'd0, if1.BSY}, 8'h01);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Reset mid-run, then load during a run
      step(1'b0, 1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("t6.Q55", if0.Q, 8'h55);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      chk("t6.rstQ", if0.Q, 8'h00);
      chk("t6.rstBSY", {7'd0, if0.BSY}, 8'h00);
      step(1'b0, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      chk("t6.Q33", if0.Q, 8'h33);
      chk("t6.idle", {7'd0, if0.BSY}, 8'h00);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0),
              4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 299) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
